// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one pmem port between I-cache and D-cache miss paths
module mem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int LINE_W       = 128,
  parameter int D_STREAK_MAX = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              icache_read,
  input  logic [ADDR_W-1:0] icache_address,
  output logic              icache_resp,
  output logic [LINE_W-1:0] icache_rdata,
  input  logic              dcache_read,
  input  logic              dcache_write,
  input  logic [ADDR_W-1:0] dcache_address,
  input  logic [LINE_W-1:0] dcache_wdata,
  output logic              dcache_resp,
  output logic [LINE_W-1:0] dcache_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata
);

  localparam int SW = $clog2(D_STREAK_MAX + 1);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  state_t          state, state_next;
  logic            op_wr;
  logic [SW-1:0]   d_streak;
  logic            d_req;
  logic            grant_i, grant_d;

  assign d_req = dcache_read | dcache_write;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    grant_i      = 1'b0;
    grant_d      = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    icache_resp  = 1'b0;
    dcache_resp  = 1'b0;
    icache_rdata = '0;
    dcache_rdata = '0;
    case (state)
      IDLE: begin
        // D wins unless the I side has already waited out its streak allowance
        if (d_req && !(icache_read && d_streak == SW'(D_STREAK_MAX))) begin
          grant_d    = 1'b1;
          state_next = SERVE_D;
        end else if (icache_read) begin
          grant_i    = 1'b1;
          state_next = SERVE_I;
        end
      end
      SERVE_I: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          icache_resp  = 1'b1;
          icache_rdata = pmem_rdata;
          state_next   = IDLE;
        end
      end
      SERVE_D: begin
        pmem_read  = ~op_wr;
        pmem_write = op_wr;
        if (pmem_resp) begin
          dcache_resp  = 1'b1;
          dcache_rdata = pmem_rdata;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_wr        <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      d_streak     <= '0;
    end else if (grant_i) begin
      pmem_address <= icache_address;
      d_streak     <= '0;
    end else if (grant_d) begin
      pmem_address <= dcache_address;
      pmem_wdata   <= dcache_wdata;
      // write wins when both strobes are (illegally) high
      op_wr        <= dcache_write;
      if (!icache_read)                        d_streak <= '0;
      else if (d_streak != SW'(D_STREAK_MAX))  d_streak <= d_streak + SW'(1);
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter
module tb_mem_arbiter;
  localparam int AW = 16;
  localparam int LW = 128;
  localparam int SMAX = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          icache_read;
  logic [AW-1:0] icache_address;
  logic          icache_resp;
  logic [LW-1:0] icache_rdata;
  logic          dcache_read, dcache_write;
  logic [AW-1:0] dcache_address;
  logic [LW-1:0] dcache_wdata;
  logic          dcache_resp;
  logic [LW-1:0] dcache_rdata;
  logic          pmem_read, pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic          pmem_resp;
  logic [LW-1:0] pmem_rdata;

  int total = 0;
  int bad = 0;
  int m_streak = 0;
  string grant_log;

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .D_STREAK_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .icache_read(icache_read), .icache_address(icache_address),
    .icache_resp(icache_resp), .icache_rdata(icache_rdata),
    .dcache_read(dcache_read), .dcache_write(dcache_write),
    .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
    .dcache_resp(dcache_resp), .dcache_rdata(dcache_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [LW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference arbitration: returns 1 for a D grant and advances the streak count
  function automatic bit model_grant_d(bit ireq, bit dreq);
    bit gd;
    gd = dreq && !(ireq && m_streak == SMAX);
    if (gd) m_streak = ireq ? ((m_streak < SMAX) ? m_streak + 1 : SMAX) : 0;
    else    m_streak = 0;
    grant_log = {grant_log, gd ? "D" : "I"};
    return gd;
  endfunction

  // Called at an IDLE negedge with requests already driven; plays the memory side
  task automatic serve(input bit is_d, input logic [AW-1:0] addr, input bit wr,
                       input logic [LW-1:0] wdata, input int lat, input logic [LW-1:0] rd);
    int n = 0;
    bit got = 0;
    bit exp_rd, exp_wr;
    exp_wr = is_d && wr;
    exp_rd = !exp_wr;
    while (!got && n < 8) begin
      @(negedge clk);
      n++;
      if (pmem_read || pmem_write) got = 1;
    end
    total++;
    if (!got || n != 1) begin
      bad++;
      $display("FAIL grant_latency: got=%0d cycles=%0d, want strobe after 1 cycle", got, n);
      return;
    end
    total++;
    if ({pmem_read, pmem_write} !== {exp_rd, exp_wr}) begin
      bad++;
      $display("FAIL strobes: rd/wr=%b%b want %b%b", pmem_read, pmem_write, exp_rd, exp_wr);
    end
    total++;
    if (pmem_address !== addr) begin
      bad++;
      $display("FAIL address: got=%h want=%h (is_d=%0d)", pmem_address, addr, is_d);
    end
    if (is_d) begin
      total++;
      if (pmem_wdata !== wdata) begin
        bad++;
        $display("FAIL wdata: got=%h want=%h", pmem_wdata, wdata);
      end
    end
    for (int k = 0; k < lat; k++) begin
      if (k > 0) @(negedge clk);
      else       @(negedge clk);
      total++;
      if ({pmem_read, pmem_write, icache_resp, dcache_resp} !== {exp_rd, exp_wr, 2'b00}) begin
        bad++;
        $display("FAIL wait_state: rd/wr/iresp/dresp=%b%b%b%b want %b%b00",
                 pmem_read, pmem_write, icache_resp, dcache_resp, exp_rd, exp_wr);
      end
    end
    pmem_rdata = rd;
    pmem_resp = 1'b1;
    #1;
    total++;
    if ({icache_resp, dcache_resp} !== {!is_d, is_d} ||
        (is_d ? dcache_rdata : icache_rdata) !== rd ||
        (is_d ? icache_rdata : dcache_rdata) !== '0) begin
      bad++;
      $display("FAIL resp: iresp=%b dresp=%b irdata=%h drdata=%h want is_d=%0d data=%h",
               icache_resp, dcache_resp, icache_rdata, dcache_rdata, is_d, rd);
    end
    @(negedge clk);
    pmem_resp = 1'b0;
    pmem_rdata = rand_line();
    #1;
    total++;
    if ({pmem_read, pmem_write, icache_resp, dcache_resp} !== 4'b0000 ||
        icache_rdata !== '0 || dcache_rdata !== '0) begin
      bad++;
      $display("FAIL idle_after: rd/wr/iresp/dresp=%b%b%b%b irdata=%h drdata=%h want all 0",
               pmem_read, pmem_write, icache_resp, dcache_resp, icache_rdata, dcache_rdata);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    icache_read = 0; icache_address = '0;
    dcache_read = 0; dcache_write = 0; dcache_address = '0; dcache_wdata = '0;
    pmem_resp = 1'b1; pmem_rdata = rand_line();
    repeat (3) @(negedge clk);
    #1;
    total++;
    if ({pmem_read, pmem_write, icache_resp, dcache_resp} !== 4'b0000 ||
        pmem_address !== '0 || pmem_wdata !== '0 ||
        icache_rdata !== '0 || dcache_rdata !== '0) begin
      bad++;
      $display("FAIL reset_state: rd/wr/iresp/dresp=%b%b%b%b addr=%h wdata=%h want 0",
               pmem_read, pmem_write, icache_resp, dcache_resp, pmem_address, pmem_wdata);
    end
    pmem_resp = 1'b0;
    reset = 1'b0;
    m_streak = 0;
    @(negedge clk);
  endtask

  task automatic test_i_read();
    icache_read = 1; icache_address = 16'h1230;
    serve(model_grant_d(1, 0), 16'h1230, 0, '0, 3, {16{8'hA5}});
    icache_read = 0;
  endtask

  task automatic test_d_write();
    dcache_write = 1; dcache_address = 16'h4000;
    dcache_wdata = 128'h0123456789ABCDEF0123456789ABCDEF;
    serve(model_grant_d(0, 1), 16'h4000, 1, 128'h0123456789ABCDEF0123456789ABCDEF, 1, rand_line());
    dcache_write = 0;
  endtask

  task automatic test_simultaneous();
    bit gd;
    icache_read = 1; icache_address = 16'h1000;
    dcache_read = 1; dcache_address = 16'h2000;
    gd = model_grant_d(1, 1);
    serve(gd, 16'h2000, 0, dcache_wdata, 2, rand_line());
    dcache_read = 0;
    serve(model_grant_d(1, 0), 16'h1000, 0, '0, 0, rand_line());
    icache_read = 0;
  endtask

  task automatic test_starvation();
    bit gd;
    int d_left = 3;
    grant_log = "";
    icache_read = 1; icache_address = 16'h0BEE;
    while (d_left > 0 || icache_read) begin
      dcache_read = (d_left > 0);
      dcache_address = 16'h7000 + AW'(d_left);
      gd = model_grant_d(icache_read, dcache_read);
      serve(gd, gd ? dcache_address : icache_address, 0, dcache_wdata,
            $urandom_range(2, 0), rand_line());
      if (gd) d_left--;
      else    icache_read = 0;
    end
    dcache_read = 0;
    total++;
    if (grant_log != "DDID") begin
      bad++;
      $display("FAIL starvation_order: model order=%s want DDID", grant_log);
    end
  endtask

  task automatic test_stray_resp();
    pmem_resp = 1'b1; pmem_rdata = rand_line();
    #1;
    total++;
    if ({icache_resp, dcache_resp} !== 2'b00 || icache_rdata !== '0 || dcache_rdata !== '0) begin
      bad++;
      $display("FAIL stray_resp: iresp=%b dresp=%b want 00", icache_resp, dcache_resp);
    end
    @(negedge clk);
    pmem_resp = 1'b0;
    total++;
    if ({pmem_read, pmem_write} !== 2'b00) begin
      bad++;
      $display("FAIL stray_state: rd/wr=%b%b want 00", pmem_read, pmem_write);
    end
  endtask

  task automatic test_both_strobes();
    dcache_read = 1; dcache_write = 1; dcache_address = 16'hBEEF;
    dcache_wdata = rand_line();
    serve(model_grant_d(0, 1), 16'hBEEF, 1, dcache_wdata, 1, rand_line());
    dcache_read = 0; dcache_write = 0;
  endtask

  task automatic test_reset_mid();
    dcache_read = 1; dcache_address = 16'h3000;
    @(negedge clk);
    total++;
    if (pmem_read !== 1'b1 || pmem_address !== 16'h3000) begin
      bad++;
      $display("FAIL mid_grant: rd=%b addr=%h want 1/3000", pmem_read, pmem_address);
    end
    reset = 1'b1; dcache_read = 0;
    @(negedge clk);
    total++;
    if ({pmem_read, pmem_write, dcache_resp, icache_resp} !== 4'b0000 || pmem_address !== '0) begin
      bad++;
      $display("FAIL mid_reset: rd/wr/dresp/iresp=%b%b%b%b addr=%h want 0",
               pmem_read, pmem_write, dcache_resp, icache_resp, pmem_address);
    end
    reset = 1'b0;
    m_streak = 0;
    @(negedge clk);
    dcache_write = 1; dcache_address = 16'h5555; dcache_wdata = rand_line();
    serve(model_grant_d(0, 1), 16'h5555, 1, dcache_wdata, 2, rand_line());
    dcache_write = 0;
  endtask

  task automatic test_random();
    bit i_pend = 0, d_pend = 0, gd;
    int op = 0;
    for (int t = 0; t < 40; t++) begin
      if (!i_pend && $urandom_range(1, 0) == 1) begin
        i_pend = 1; icache_address = AW'($urandom);
      end
      if (!d_pend && $urandom_range(1, 0) == 1) begin
        d_pend = 1; op = $urandom_range(2, 0);
        dcache_address = AW'($urandom); dcache_wdata = rand_line();
      end
      if (!i_pend && !d_pend) begin
        i_pend = 1; icache_address = AW'($urandom);
      end
      icache_read = i_pend;
      dcache_read = d_pend && (op != 1);
      dcache_write = d_pend && (op != 0);
      gd = model_grant_d(i_pend, d_pend);
      serve(gd, gd ? dcache_address : icache_address, op != 0, dcache_wdata,
            $urandom_range(3, 0), rand_line());
      if (gd) d_pend = 0;
      else    i_pend = 0;
      icache_read = i_pend;
      dcache_read = d_pend && (op != 1);
      dcache_write = d_pend && (op != 0);
    end
    icache_read = 0; dcache_read = 0; dcache_write = 0;
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_d_write();
    test_simultaneous();
    test_starvation();
    test_stray_resp();
    test_both_strobes();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
